matmul_sched: RTL and testbench

//   Issue controller for the 4x4 fp16 matrix x vec4 pipeline (matmul). Holds the transform

---
 rtl/matmul_sched.sv | 169 ++++++++++++++++
 tb/tb_matmul_sched.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_sched.sv
// matmul_sched: issue controller for the 4x4 fp16 matrix x vec4 unit (define PERF_CNT_EN for perf counters).
// Latency: out_valid rises LATENCY edges after the issue edge; out_vec is the output FIFO head.
// Backpressure: in_ready needs a credit (FIFO entries + in-flight < OUT_DEPTH) and no pending commit.

// matmul_sched_fifo: generic power-of-two FIFO with occupancy count.
// Latency: write visible at the head one edge after push; read data is combinational from the head.
// Backpressure: none internally; the writer must never push into a full FIFO without a same-cycle pop.
module matmul_sched_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_vld,
    input  logic [W-1:0]             wr_dat,
    input  logic                     rd_rdy,
    output logic                     rd_vld,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_fire;

    assign rd_vld  = (count != '0);
    assign rd_fire = rd_vld && rd_rdy;
    // Empty head reads as zero so nothing stale is ever presented.
    assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_vld)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(wr_vld) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld) mem[wr_ptr] <= wr_dat;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst)
        !(wr_vld && !rd_fire && (count == CW'(DEPTH))));
endmodule

// matmul_sched: shadow/active matrix banks, operand issue, in-flight tag tracking, credit-gated output FIFO.
// Latency: operand accepted at edge e0 appears on out_vec after edge e0+LATENCY (empty FIFO).
// Backpressure: in_ready low when out of credits or while a commit drains and copies the matrix.
module matmul_sched #(
    parameter int LATENCY   = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_we,
    input  logic [3:0]   cfg_addr,
    input  logic [15:0]  cfg_wdata,
    input  logic         cfg_commit,
    output logic         cfg_busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_vec,
    output logic [255:0] mm_a,
    output logic [63:0]  mm_b,
    input  logic [63:0]  mm_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_vec
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]  perf_vtx,
    output logic [31:0]  perf_stall
`endif
);
    localparam int CW = $clog2(OUT_DEPTH) + 1;
    localparam int SW = $clog2(OUT_DEPTH + LATENCY + 1);
    localparam logic [255:0] IDENT = {16'h3C00, 64'h0, 16'h3C00, 64'h0,
                                      16'h3C00, 64'h0, 16'h3C00};

    typedef enum logic [1:0] {RUN, DRAIN, COPY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [255:0]        shadow;
    logic [255:0]        active;
    logic [LATENCY-1:0]  tag;
    logic                issue;
    logic                push;
    logic [CW-1:0]       fifo_count;
    logic [SW-1:0]       inflight;
    logic [SW-1:0]       occupied;

    assign mm_a     = active;
    assign cfg_busy = (state != RUN);
    assign issue    = in_valid && in_ready;
    assign push     = tag[LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) inflight = inflight + SW'(tag[i]);
    end

    // Credit check uses registered counts only, so a pop frees its slot one cycle later.
    assign occupied = inflight + SW'(fifo_count);
    assign in_ready = (state == RUN) && (occupied < SW'(OUT_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_commit) state_nxt = DRAIN;
            DRAIN:   if (tag == '0)  state_nxt = COPY;
            COPY:    state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow <= IDENT;
            active <= IDENT;
            mm_b   <= '0;
            tag    <= '0;
        end else begin
            if (cfg_we && !cfg_busy) shadow[{cfg_addr, 4'b0} +: 16] <= cfg_wdata;
            if (state == COPY) active <= shadow;
            if (issue) mm_b <= in_vec;
            tag <= LATENCY'({tag, issue});
        end
    end

    matmul_sched_fifo #(
        .W     (64),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push),
        .wr_dat (mm_x),
        .rd_rdy (out_ready),
        .rd_vld (out_valid),
        .rd_dat (out_vec),
        .count  (fifo_count)
    );

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_vtx   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready) perf_vtx   <= perf_vtx + 32'd1;
            if (in_valid && !in_ready)  perf_stall <= perf_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_matmul_sched.sv
// Bench for matmul_sched: diagonal-only matmul stand-in, scoreboard of expected results, per-scenario tasks.
`timescale 1ns/1ps
module tb_matmul_sched;
    localparam int LATENCY   = 4;
    localparam int OUT_DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_we = 1'b0;
    logic [3:0]   cfg_addr = '0;
    logic [15:0]  cfg_wdata = '0;
    logic         cfg_commit = 1'b0;
    logic         cfg_busy;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_vec = '0;
    logic [255:0] mm_a;
    logic [63:0]  mm_b;
    logic [63:0]  mm_x;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_vec;
`ifdef PERF_CNT_EN
    logic [31:0]  perf_vtx;
    logic [31:0]  perf_stall;
`endif

    int           n_tests = 0;
    int           n_fail = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  exp_diag = {4{16'h3C00}};
    logic [63:0]  pipe [LATENCY-1];

    matmul_sched #(.LATENCY(LATENCY), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vec     (in_vec),
        .mm_a       (mm_a),
        .mm_b       (mm_b),
        .mm_x       (mm_x),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vec    (out_vec)
`ifdef PERF_CNT_EN
        ,
        .perf_vtx   (perf_vtx),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] scale(input logic [15:0] x, input logic [15:0] s);
        if (s == 16'h3C00) return x;
        if (s == 16'h4000) return x + 16'h0400;
        return 16'hFFFF;
    endfunction

    // Affine transform of a point: xyz scaled by the diagonal, w forced to 1.0.
    function automatic logic [63:0] mm_model(input logic [63:0] v, input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 3; j++) r[16*j +: 16] = scale(v[16*j +: 16], d[16*j +: 16]);
        r[63:48] = 16'h3C00;
        return r;
    endfunction

    function automatic logic [63:0] diag_of(input logic [255:0] a);
        return {a[240 +: 16], a[160 +: 16], a[80 +: 16], a[0 +: 16]};
    endfunction

    function automatic logic [255:0] mat_diag(input logic [15:0] d);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[80*i +: 16] = d;
        return m;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= mm_model(mm_b, diag_of(mm_a));
        for (int k = 1; k < LATENCY - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign mm_x = pipe[LATENCY-2];

    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (rst) begin
            if (out_valid && out_ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL result_stale: out_vec=%h with no result outstanding", out_vec);
                end else begin
                    e = exp_q.pop_front();
                    if (out_vec !== e) begin
                        n_fail++;
                        $display("FAIL result_data: out_vec=%h expected %h", out_vec, e);
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(mm_model(in_vec, exp_diag));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;
        exp_q.delete();
        tick(); tick();
        rst = 1'b1;
        exp_diag = {4{16'h3C00}};
        tick();
    endtask

    task automatic send(input logic [63:0] v, output bit ok);
        ok = 1'b0;
        in_valid = 1'b1; in_vec = v;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin ok = 1'b1; break; end
            tick();
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_q(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (!cfg_busy) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic write_diag(input logic [15:0] d);
        for (int i = 0; i < 4; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(5*i); cfg_wdata = d;
            tick();
        end
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_tests++; if (out_vec !== 64'h0) begin n_fail++; $display("FAIL reset_out_vec: got %h want 0", out_vec); end
        n_tests++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL reset_cfg_busy: got %b want 0", cfg_busy); end
        n_tests++; if (mm_b !== 64'h0) begin n_fail++; $display("FAIL reset_mm_b: got %h want 0", mm_b); end
        n_tests++; if (mm_a !== mat_diag(16'h3C00)) begin n_fail++; $display("FAIL reset_mm_a: got %h want identity", mm_a); end
        rst = 1'b1;
        tick();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        logic [63:0] v;
        v = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
        out_ready = 1'b1;
        in_valid = 1'b1; in_vec = v;
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_tests++; if (mm_b !== v) begin n_fail++; $display("FAIL single_mm_b: got %h want %h", mm_b, v); end
        for (int k = 1; k <= LATENCY + 1; k++) begin
            tick();
            n_tests++;
            if (out_valid !== (k == LATENCY)) begin
                n_fail++; $display("FAIL single_out_valid_edge%0d: got %b want %b", k, out_valid, (k == LATENCY));
            end
            if (k == LATENCY) begin
                n_tests++;
                if (out_vec !== 64'h3C00_4200_4000_3C00) begin
                    n_fail++; $display("FAIL single_out_vec: got %h want 3c00420040003c00", out_vec);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] v [10];
        int n;
        int stalls;
        bit acc;
        bit ok;
        do_reset();
        for (int i = 0; i < 10; i++) v[i] = {$urandom, $urandom};
        out_ready = 1'b0; n = 0; stalls = 0;
        for (int c = 0; c < 12 && n < 10; c++) begin
            in_valid = 1'b1; in_vec = v[n]; acc = in_ready;
            tick();
            if (acc) n++; else stalls++;
        end
        n_tests++; if (n != OUT_DEPTH) begin n_fail++; $display("FAIL bp_accepted: got %0d want %0d", n, OUT_DEPTH); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int c = 0; c < 80 && n < 10; c++) begin
            in_valid = 1'b1; in_vec = v[n]; acc = in_ready;
            tick();
            if (acc) n++; else stalls++;
        end
        in_valid = 1'b0;
        n_tests++; if (n != 10) begin n_fail++; $display("FAIL bp_resume: accepted %0d want 10", n); end
        drain_q(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_drain: %0d results missing", exp_q.size()); end
`ifdef PERF_CNT_EN
        n_tests++; if (perf_vtx !== 32'd10) begin n_fail++; $display("FAIL perf_vtx: got %0d want 10", perf_vtx); end
        n_tests++; if (perf_stall !== 32'(stalls)) begin n_fail++; $display("FAIL perf_stall: got %0d want %0d", perf_stall, stalls); end
`endif
    endtask

    task automatic test_commit();
        bit ok;
        bit bad;
        int busy_cyc;
        do_reset();
        out_ready = 1'b1;
        write_diag(16'h4000);
        n_tests++; if (mm_a !== mat_diag(16'h3C00)) begin n_fail++; $display("FAIL commit_shadow_isolated: mm_a=%h want identity", mm_a); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_vec = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        n_tests++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL commit_busy: got %b want 1", cfg_busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL commit_in_ready: got %b want 0", in_ready); end
        bad = 1'b0; busy_cyc = 0;
        while (cfg_busy && busy_cyc < 20) begin
            if (in_ready) bad = 1'b1;
            tick();
            busy_cyc++;
        end
        n_tests++; if (bad) begin n_fail++; $display("FAIL commit_ready_while_busy: in_ready=1 want 0"); end
        n_tests++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL commit_done: cfg_busy=%b after %0d cycles want 0", cfg_busy, busy_cyc); end
        n_tests++; if (mm_a !== mat_diag(16'h4000)) begin n_fail++; $display("FAIL commit_mm_a: got %h want diag 4000", mm_a); end
        exp_diag = {4{16'h4000}};
        send({4{16'h3C00}}, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL commit_send: in_ready=0 want 1"); end
        drain_q(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL commit_drain: %0d results missing", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit acc;
        bit ok;
        out_ready = 1'b1; n = 0;
        for (int c = 0; c < 60 && n < 8; c++) begin
            in_valid = 1'b1; in_vec = {$urandom, $urandom}; acc = in_ready;
            tick();
            if (acc) n++;
        end
        in_valid = 1'b0;
        n_tests++; if (n != 8) begin n_fail++; $display("FAIL b2b_accepted: got %0d want 8", n); end
        drain_q(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_drain: %0d results missing", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen;
        do_reset();
        out_ready = 1'b1;
        write_diag(16'h4000);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        wait_idle(ok);
        exp_diag = {4{16'h4000}};
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_vec = {16'h3C00, 16'h3800 + 16'(c), 16'h3400 + 16'(c), 16'h3000 + 16'(c)};
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_tests++; if (mm_a !== mat_diag(16'h3C00)) begin n_fail++; $display("FAIL rstmid_mm_a: got %h want identity", mm_a); end
        n_tests++; if (mm_b !== 64'h0) begin n_fail++; $display("FAIL rstmid_mm_b: got %h want 0", mm_b); end
        tick(); tick();
        rst = 1'b1;
        exp_diag = {4{16'h3C00}};
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (out_valid) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale: out_valid seen %0d cycles want 0", seen); end
    endtask

    task automatic test_cfg_ignore();
        bit ok;
        int cnt;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_vec = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; cfg_commit = 1'b1;
        tick();
        cnt = 0;
        while (cfg_busy && cnt < 20) begin
            cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 16'h4000; cfg_commit = 1'b1;
            tick();
            cnt++;
        end
        cfg_we = 1'b0; cfg_commit = 1'b0;
        n_tests++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL ign_busy_done: cfg_busy=%b want 0", cfg_busy); end
        n_tests++; if (mm_a !== mat_diag(16'h3C00)) begin n_fail++; $display("FAIL ign_mm_a: got %h want identity", mm_a); end
        tick();
        n_tests++; if (cfg_busy !== 1'b0) begin n_fail++; $display("FAIL ign_commit_queued: cfg_busy=%b want 0", cfg_busy); end
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        wait_idle(ok);
        n_tests++; if (mm_a !== mat_diag(16'h3C00)) begin n_fail++; $display("FAIL ign_shadow: mm_a=%h want identity", mm_a); end
        send({4{16'h3C00}}, ok);
        drain_q(ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL ign_drain: %0d results missing", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_commit();
        test_back_to_back();
        test_reset_mid();
        test_cfg_ignore();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end
endmodule
